// File: rtl/sm_2c_lane_converter.sv
// Multi-lane sign-magnitude <-> two's-complement converter with a one-deep registered
// valid/ready output stage and a saturating count of exception-flagged lanes.
module sm_2c_lane_converter #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_mode,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_mode,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [LANES-1:0]            out_flags,
  output logic [CNT_WIDTH-1:0]        err_count,
  input  logic                        clr_count
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = CNT_WIDTH + $clog2(LANES + 1) + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_WIDTH{1'b1}});

  // Returns {flag, converted lane}
  function automatic logic [W:0] sm_to_2c(input logic [W-1:0] x);
    logic [W-1:0] mag;
    logic [W:0]   res;
    mag = {1'b0, x[W-2:0]};
    res = {1'b0, mag};
    if (x[W-1]) begin
      if (mag == '0) res = {1'b1, {W{1'b0}}};
      else           res = {1'b0, ~mag + 1'b1};
    end
    return res;
  endfunction

  // The most negative code has no sign-magnitude form; it saturates to all ones
  function automatic logic [W:0] tc_to_sm(input logic [W-1:0] x);
    logic [W-1:0] neg;
    logic [W:0]   res;
    neg = ~x + 1'b1;
    res = {1'b0, x};
    if (x[W-1]) begin
      if (x[W-2:0] == '0) res = {1'b1, {W{1'b1}}};
      else                res = {1'b0, 1'b1, neg[W-2:0]};
    end
    return res;
  endfunction

  logic                        out_valid_d, out_valid_q;
  logic                        out_mode_d,  out_mode_q;
  logic [LANES*DATA_WIDTH-1:0] out_data_d,  out_data_q;
  logic [LANES-1:0]            out_flags_d, out_flags_q;
  logic [CNT_WIDTH-1:0]        err_count_d, err_count_q;

  logic [LANES*DATA_WIDTH-1:0] conv_data;
  logic [LANES-1:0]            conv_flags;
  logic [SW-1:0]               pop;
  logic [SW-1:0]               cnt_sum;
  logic                        accept;

  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    logic [W:0] lane_res;
    conv_data  = '0;
    conv_flags = '0;
    pop        = '0;
    lane_res   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_mode) lane_res = tc_to_sm(in_data[i*W +: W]);
      else         lane_res = sm_to_2c(in_data[i*W +: W]);
      conv_data[i*W +: W] = lane_res[W-1:0];
      conv_flags[i]       = lane_res[W];
      pop                 = pop + SW'(lane_res[W]);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_mode_d  = out_mode_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    err_count_d = err_count_q;
    cnt_sum     = '0;

    if (accept) begin
      out_valid_d = 1'b1;
      out_mode_d  = in_mode;
      out_data_d  = conv_data;
      out_flags_d = conv_flags;
      // Clear applies before the new flags are added
      cnt_sum     = (clr_count ? '0 : SW'(err_count_q)) + pop;
      err_count_d = (cnt_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];
    end else begin
      if (out_ready) out_valid_d = 1'b0;
      if (clr_count) err_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_mode_q  <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_mode_q  <= out_mode_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mode  = out_mode_q;
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_sm_2c_lane_converter.sv
// Self-checking bench for sm_2c_lane_converter (4-bit lanes, 2 lanes, 3-bit counter):
// fixed vector table, hand-written corner sequences, and a randomized run vs an arithmetic model.
module tb_sm_2c_lane_converter;

  localparam int W = 4;
  localparam int L = 2;
  localparam int C = 3;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_mode, out_ready, clr_count;
  logic           in_ready, out_valid, out_mode;
  logic [L*W-1:0] in_data, out_data;
  logic [L-1:0]   out_flags;
  logic [C-1:0]   err_count;

  int checks = 0;
  int errors = 0;

  // Reference state: what the output registers should hold
  bit             m_valid, m_mode;
  logic [L*W-1:0] m_data;
  logic [L-1:0]   m_flags;
  int             m_cnt;

  sm_2c_lane_converter #(.DATA_WIDTH(W), .LANES(L), .CNT_WIDTH(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_data(out_data), .out_flags(out_flags), .err_count(err_count), .clr_count(clr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-lane conversion computed from signed values with plain arithmetic
  function automatic void conv_lane(input bit mode, input logic [W-1:0] x,
                                    output logic [W-1:0] y, output bit f);
    int v, m;
    f = 0;
    if (!mode) begin
      m = int'(x) % 8;
      v = (x >= 8) ? -m : m;
      f = (x == 8);
      y = W'(v & 15);
    end else begin
      v = (x >= 8) ? int'(x) - 16 : int'(x);
      if (v == -8) begin
        y = 4'hF;
        f = 1;
      end else if (v < 0) y = W'(8 - v);
      else                y = W'(v);
    end
  endfunction

  function automatic void conv_all(input bit mode, input logic [L*W-1:0] x,
                                   output logic [L*W-1:0] y, output logic [L-1:0] f);
    logic [W-1:0] yl;
    bit           fl;
    y = '0;
    f = '0;
    for (int i = 0; i < L; i++) begin
      conv_lane(mode, x[i*W +: W], yl, fl);
      y[i*W +: W] = yl;
      f[i]        = fl;
    end
  endfunction

  // One clock: inputs driven at the falling edge, outputs checked at the next falling edge
  task automatic cycle(input bit r, input bit v, input bit mode, input logic [L*W-1:0] d,
                       input bit ordy, input bit clr);
    logic [L*W-1:0] yd;
    logic [L-1:0]   yf;
    bit             exp_rdy, acc;
    int             pop;
    rst = r; in_valid = v; in_mode = mode; in_data = d; out_ready = ordy; clr_count = clr;
    #1;
    exp_rdy = !r && (!m_valid || ordy);
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    acc = v && exp_rdy;
    conv_all(mode, d, yd, yf);
    pop = int'(yf[0]) + int'(yf[1]);
    if (r) begin
      m_valid = 0; m_mode = 0; m_data = '0; m_flags = '0; m_cnt = 0;
    end else if (acc) begin
      m_valid = 1; m_mode = mode; m_data = yd; m_flags = yf;
      m_cnt = (clr ? 0 : m_cnt) + pop;
      if (m_cnt > 7) m_cnt = 7;
    end else begin
      if (ordy) m_valid = 0;
      if (clr)  m_cnt = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", int'(out_valid), int'(m_valid));
    chk("out_data", int'(out_data), int'(m_data));
    chk("out_flags", int'(out_flags), int'(m_flags));
    chk("out_mode", int'(out_mode), int'(m_mode));
    chk("err_count", int'(err_count), m_cnt);
  endtask

  typedef struct {
    bit             mode;
    logic [L*W-1:0] din;
    logic [L*W-1:0] dout;
    logic [L-1:0]   flags;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [L*W-1:0] held, fwd;
    int             cnt_before;

    tbl[0] = '{1'b0, 8'b1011_0101, 8'b1101_0101, 2'b00};
    tbl[1] = '{1'b0, 8'b0011_1000, 8'b0011_0000, 2'b01};
    tbl[2] = '{1'b1, 8'b1101_1000, 8'b1011_1111, 2'b01};
    tbl[3] = '{1'b1, 8'b0111_1001, 8'b0111_1111, 2'b00};
    tbl[4] = '{1'b0, 8'b1111_1001, 8'b1001_1111, 2'b00};
    tbl[5] = '{1'b0, 8'b1000_1000, 8'b0000_0000, 2'b11};
    tbl[6] = '{1'b1, 8'b1000_0000, 8'b1111_0000, 2'b10};

    m_valid = 0; m_mode = 0; m_data = '0; m_flags = '0; m_cnt = 0;
    rst = 1; in_valid = 0; in_mode = 0; in_data = '0; out_ready = 1; clr_count = 0;
    @(negedge clk);
    cycle(1, 0, 0, '0, 1, 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_err_count", int'(err_count), 0);

    // Fixed vectors, checked against literal expectations
    for (int i = 0; i < 7; i++) begin
      cnt_before = int'(err_count);
      cycle(0, 1, tbl[i].mode, tbl[i].din, 1, 0);
      chk($sformatf("tbl%0d_data", i), int'(out_data), int'(tbl[i].dout));
      chk($sformatf("tbl%0d_flags", i), int'(out_flags), int'(tbl[i].flags));
      chk($sformatf("tbl%0d_cnt", i), int'(err_count),
          (cnt_before + int'(tbl[i].flags[0]) + int'(tbl[i].flags[1]) > 7) ? 7
          : cnt_before + int'(tbl[i].flags[0]) + int'(tbl[i].flags[1]));
    end

    // Saturation at 7, then clear together with a 2-flag transaction
    cycle(0, 0, 0, '0, 1, 1);
    chk("clr_alone", int'(err_count), 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'b1000_1000, 1, 0);
    chk("sat_7", int'(err_count), 7);
    cycle(0, 1, 0, 8'b0001_1000, 1, 0);
    chk("sat_hold", int'(err_count), 7);
    cycle(0, 1, 0, 8'b1000_1000, 1, 1);
    chk("clr_with_accept", int'(err_count), 2);

    // Backpressure: 3 stalled cycles, then 4 back-to-back transactions
    cycle(0, 1, 0, 8'b0001_1010, 0, 0);
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, 8'(8'hA0 + i), 0, 0);
      chk("stall_ready", int'(in_ready), 0);
      chk("stall_stable", int'(out_data), int'(held));
    end
    for (int i = 0; i < 4; i++) cycle(0, 1, i[0], 8'(8'h31 + 8'h11 * i), 1, 0);
    cycle(0, 0, 0, '0, 1, 0);
    chk("drain", int'(out_valid), 0);

    // Reset in the middle of a stall
    cycle(0, 1, 0, 8'b1000_0001, 0, 0);
    cycle(0, 1, 0, 8'b0000_0001, 0, 0);
    cycle(1, 1, 0, 8'b1000_1000, 0, 0);
    chk("rst_stall_valid", int'(out_valid), 0);
    chk("rst_stall_cnt", int'(err_count), 0);
    cycle(0, 0, 0, '0, 0, 0);
    chk("rst_release_ready", int'(in_ready), 1);

    // Exhaustive round trip SM->2C->SM on every 4-bit code
    for (int x = 0; x < 16; x++) begin
      logic [W-1:0] xv;
      xv = W'(x);
      cycle(0, 1, 0, {~xv, xv}, 1, 0);
      fwd = out_data;
      cycle(0, 1, 1, fwd, 1, 0);
      chk($sformatf("rt_lane0_%0d", x), int'(out_data[W-1:0]), (x == 8) ? 0 : x);
      chk($sformatf("rt_lane1_%0d", x), int'(out_data[2*W-1:W]),
          ((15 - x) == 8) ? 0 : 15 - x);
    end

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
